if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end that produces the `if_pc`/`if_inst` pair consumed by the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake to instruction memory, which may have variable latency.
- Honours `stall` from ctrl and branch redirects from ID.
- Emits a NOP bubble (`if_inst_o`=0, `if_valid_o`=0) whenever no fetched instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_0020, redirect address for a misaligned target. Used only with FETCH_MISALIGN_EXC_EN.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (0 = reset)
- stall  in  1  1 = downstream frozen; `if_*` outputs must hold
- branch_flag_i  in  1  redirect request from ID
- branch_target_i  in  32  redirect address
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address; stable while req=1 and ack=0
- imem_ack_i  in  1  memory returns data this cycle (may coincide with req's first cycle)
- imem_rdata_i  in  32  instruction word, valid with ack
- if_pc_o  out  32  PC of `if_inst_o`
- if_inst_o  out  32  instruction; 0 (NOP) on bubble
- if_valid_o  out  1  1 = `if_inst_o` is a real fetched instruction
- if_excp_o  out  1  misaligned-fetch exception marker; tied 0 without the macro

Behaviour:
- Reset (rst=0 at posedge):
  - state=RST; pc=RESET_PC.
  - imem_req_o=0; if_pc_o=0, if_inst_o=0, if_valid_o=0, if_excp_o=0.
  - Overrides everything, including a request outstanding mid-handshake; memory must tolerate the abandoned request.
- States and transitions:
  - RST: req=0. Next cycle → FETCH.
  - FETCH: req=1, addr=req_addr.
    - ack & !redirect & !stall: outputs <= {req_addr, rdata, valid=1}; req_addr <= req_addr+4; stay in FETCH (back-to-back, 1 instr/cycle with zero-wait memory).
    - ack & !redirect & stall: rdata → hold buffer; → HOLD.
    - !ack & redirect: target latched; → DISCARD. req/addr are held unchanged until ack (protocol rule: never drop or alter a request mid-handshake).
    - ack & redirect: data dropped; req_addr <= target; stay in FETCH.
  - HOLD: req=0.
    - !stall: outputs <= buffer (valid=1); req_addr += 4; → FETCH.
    - redirect: buffer dropped; req_addr <= target; → FETCH. Redirect wins over stall release.
  - DISCARD: req=1 at the old address.
    - On ack: data dropped; req_addr <= latched target; → FETCH.
    - A further redirect while in DISCARD overwrites the latched target.
- Output update rule:
  - `if_*` outputs change only in cycles with stall=0.
  - In a stall=0 cycle with no instruction delivered (no ack, DISCARD, redirect cycle, RST): bubble — if_inst_o=0, if_valid_o=0, if_pc_o unchanged.
- Latency: instruction appears on outputs the cycle after its ack.
- Arithmetic:
  - pc+4 is modulo 2^32 (32'hFFFF_FFFC → 0).
  - Without the macro, branch_target_i[1:0] are forced to 00.
- Simultaneous events:
  - redirect and stall in the same cycle: redirect is taken; outputs hold.
  - redirect during RST-exit cycle: target replaces RESET_PC for the first fetch.

Optional Feature:
- Macro: FETCH_MISALIGN_EXC_EN.
- Defined: a redirect with target[1:0]≠0 issues no fetch. On the next stall=0 output cycle, the block emits {if_pc_o=raw target, if_inst_o=0, if_valid_o=1, if_excp_o=1} for exactly one cycle, then fetches from EXC_VECTOR.
  - If a request is outstanding, it is first drained as in DISCARD.
- Undefined: low bits silently cleared; if_excp_o constant 0.

Test Plan:
- Reset release, zero-wait memory (ack=req), stall=0 → req high in 2nd cycle after rst=1. Outputs: pc 0,4,8,… valid=1 each cycle; 0 bubble on first output cycle.
- 3-cycle memory latency at pc=0x100 → 2 bubble cycles, then {0x100, rdata, valid=1}; next req addr=0x104.
- Ack while stall=1 for 4 cycles → outputs frozen, req=0 during HOLD. On stall=0, buffered instr appears, then fetch resumes at +4.
- Redirect to 0x200 while request to 0x40 is pending (ack 2 cycles later) → addr stays 0x40 until ack, data discarded, next req addr=0x200, no valid output from 0x40.
- Reset asserted mid-handshake → next cycle req=0, all outputs 0; after release, fetch from RESET_PC.
- With FETCH_MISALIGN_EXC_EN: redirect to 0x302 → one output {0x302, 0, valid=1, excp=1}, then fetch at 0x20. Without the macro: fetch at 0x300, excp=0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC and runs a req/ack handshake to instruction memory.
// Define FETCH_MISALIGN_EXC_EN to turn misaligned redirect targets into a fetch exception.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        if_excp_o
);

`ifdef FETCH_MISALIGN_EXC_EN
    localparam bit MisalignExc = 1'b1;
`else
    localparam bit MisalignExc = 1'b0;
`endif

    localparam logic [2:0] ST_RST     = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_DISCARD = 3'd3;
    localparam logic [2:0] ST_EXC     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        excp_q, excp_d;

    logic [31:0] redir_tgt;
    logic        go;
    logic [31:0] go_tgt;

    // Raw target is kept only when misalignment is reported; otherwise the low bits are dropped.
    assign redir_tgt = MisalignExc ? branch_target_i : {branch_target_i[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        tgt_d      = tgt_q;
        buf_d      = buf_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        excp_d     = excp_q;
        go         = 1'b0;
        go_tgt     = redir_tgt;

        // Any unstalled cycle that delivers nothing becomes a bubble; pc is left alone.
        if (!stall) begin
            inst_d  = '0;
            valid_d = 1'b0;
            excp_d  = 1'b0;
        end

        unique case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
                go      = branch_flag_i;
            end
            ST_FETCH: begin
                if (branch_flag_i) begin
                    if (imem_ack_i) begin
                        go = 1'b1;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = ST_DISCARD;
                    end
                end else if (imem_ack_i) begin
                    if (stall) begin
                        buf_d   = imem_rdata_i;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d       = req_addr_q;
                        inst_d     = imem_rdata_i;
                        valid_d    = 1'b1;
                        req_addr_d = req_addr_q + 32'd4;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_flag_i) begin
                    go = 1'b1;
                end else if (!stall) begin
                    pc_d       = req_addr_q;
                    inst_d     = buf_q;
                    valid_d    = 1'b1;
                    req_addr_d = req_addr_q + 32'd4;
                    state_d    = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // The outstanding request must complete before the new target is used.
                if (imem_ack_i) begin
                    go = 1'b1;
                    if (!branch_flag_i) go_tgt = tgt_q;
                end else if (branch_flag_i) begin
                    tgt_d = redir_tgt;
                end
            end
            ST_EXC: begin
                if (branch_flag_i) begin
                    go = 1'b1;
                end else if (!stall) begin
                    pc_d       = tgt_q;
                    inst_d     = '0;
                    valid_d    = 1'b1;
                    excp_d     = 1'b1;
                    req_addr_d = EXC_VECTOR;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (go) begin
            tgt_d = go_tgt;
            if (MisalignExc && (go_tgt[1:0] != 2'b00)) begin
                state_d = ST_EXC;
            end else begin
                state_d    = ST_FETCH;
                req_addr_d = go_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RST;
            req_addr_q <= RESET_PC;
            tgt_q      <= '0;
            buf_q      <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
            excp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            tgt_q      <= tgt_d;
            buf_q      <= buf_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            excp_q     <= excp_d;
        end
    end

    assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem_addr_o = req_addr_q;
    assign if_pc_o     = pc_q;
    assign if_inst_o   = inst_q;
    assign if_valid_o  = valid_q;
    assign if_excp_o   = MisalignExc ? excp_q : 1'b0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: variable-latency memory model plus a scoreboard of delivered instructions.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        if_excp_o;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int wcnt = 0;
    logic upd = 1'b0;
    logic [64:0] obs_q[$];
    logic [64:0] exp_q[$];
    logic [64:0] exp_e;
    logic [64:0] obs_e;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o),
        .if_excp_o       (if_excp_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [64:0] ent(input logic [31:0] pc, input logic excp);
        return {pc, excp ? 32'h0 : mem_word(pc), excp};
    endfunction

    // Memory: ack arrives on the lat-th cycle a request is presented (lat=1 is zero-wait).
    always @(negedge clk) begin
        if (imem_req_o === 1'b1) begin
            if (wcnt >= lat - 1) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                wcnt         = 0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'hDEAD_BEEF;
                wcnt         = wcnt + 1;
            end
        end else begin
            imem_ack_i = 1'b0;
            wcnt       = 0;
        end
    end

    always @(posedge clk) upd <= rst && !stall;

    always @(negedge clk) begin
        if (upd === 1'b1 && if_valid_o === 1'b1) obs_q.push_back({if_pc_o, if_inst_o, if_excp_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        tick();
        tick();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic release_rst(input logic flag, input logic [31:0] tgt);
        rst = 1'b1;
        branch_flag_i = flag;
        branch_target_i = tgt;
        tick();
        branch_flag_i = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 60) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        lat = 1;
        do_reset();
        checks++;
        if ({imem_req_o, if_pc_o, if_inst_o, if_valid_o, if_excp_o} !== 67'h0) begin
            failures++;
            $display("FAIL rst_outputs: got req=%b pc=%h inst=%h v=%b x=%b, want all 0",
                     imem_req_o, if_pc_o, if_inst_o, if_valid_o, if_excp_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_first_req: got req=%b addr=%h, want 1/00000000",
                     imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_zero_wait();
        lat = 1;
        do_reset();
        release_rst(1'b0, 32'h0);
        checks++;
        if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin
            failures++;
            $display("FAIL zw_bubble: got v=%b inst=%h, want 0/0", if_valid_o, if_inst_o);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'(i * 4), 1'b0));
        wait_obs(8);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL zw_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL zw_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_latency();
        lat = 3;
        do_reset();
        release_rst(1'b1, 32'h100);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL lat_addr: got req=%b addr=%h, want 1/00000100", imem_req_o, imem_addr_o);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(ent(32'h100 + 32'(i * 4), 1'b0));
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (if_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL lat_bubble%0d: got v=%b, want 0", i, if_valid_o);
            end
        end
        tick();
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || imem_addr_o !== 32'h104) begin
            failures++;
            $display("FAIL lat_first: got v=%b pc=%h addr=%h, want 1/00000100/00000104",
                     if_valid_o, if_pc_o, imem_addr_o);
        end
        wait_obs(3);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL lat_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL lat_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        lat = 1;
        do_reset();
        release_rst(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'(i * 4), 1'b0));
        tick();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== 32'h0 ||
                if_inst_o !== mem_word(32'h0)) begin
                failures++;
                $display("FAIL hold_frozen%0d: got req=%b v=%b pc=%h inst=%h, want 0/1/0/%h",
                         i, imem_req_o, if_valid_o, if_pc_o, if_inst_o, mem_word(32'h0));
            end
            tick();
        end
        stall = 1'b0;
        wait_obs(4);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL hold_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL hold_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_hold_redirect();
        lat = 1;
        do_reset();
        release_rst(1'b0, 32'h0);
        exp_q.push_back(ent(32'h0, 1'b0));
        exp_q.push_back(ent(32'h80, 1'b0));
        exp_q.push_back(ent(32'h84, 1'b0));
        tick();
        stall = 1'b1;
        tick();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h80;
        tick();
        branch_flag_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80 || if_pc_o !== 32'h0 ||
            if_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL hredir_state: got req=%b addr=%h pc=%h v=%b, want 1/00000080/0/1",
                     imem_req_o, imem_addr_o, if_pc_o, if_valid_o);
        end
        stall = 1'b0;
        wait_obs(3);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL hredir_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL hredir_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_discard();
        lat = 3;
        do_reset();
        release_rst(1'b1, 32'h40);
        exp_q.push_back(ent(32'h200, 1'b0));
        exp_q.push_back(ent(32'h204, 1'b0));
        branch_flag_i = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
                failures++;
                $display("FAIL disc_held%0d: got req=%b addr=%h, want 1/00000040",
                         i, imem_req_o, imem_addr_o);
            end
            tick();
        end
        checks++;
        if (imem_addr_o !== 32'h200 || if_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL disc_target: got addr=%h v=%b, want 00000200/0", imem_addr_o, if_valid_o);
        end
        wait_obs(2);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL disc_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL disc_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset();
        release_rst(1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(ent(32'hFFFF_FFFC, 1'b0));
        exp_q.push_back(ent(32'h0, 1'b0));
        exp_q.push_back(ent(32'h4, 1'b0));
        wait_obs(3);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL wrap_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL wrap_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_misalign();
        int n;
        lat = 1;
        do_reset();
        release_rst(1'b1, 32'h302);
`ifdef FETCH_MISALIGN_EXC_EN
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL mis_noreq: got req=%b, want 0", imem_req_o);
        end
        exp_q.push_back(ent(32'h302, 1'b1));
        exp_q.push_back(ent(32'h20, 1'b0));
        exp_q.push_back(ent(32'h24, 1'b0));
`else
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin
            failures++;
            $display("FAIL mis_align: got req=%b addr=%h, want 1/00000300", imem_req_o, imem_addr_o);
        end
        exp_q.push_back(ent(32'h300, 1'b0));
        exp_q.push_back(ent(32'h304, 1'b0));
`endif
        n = exp_q.size();
        wait_obs(n);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL mis_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL mis_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        do_reset();
        release_rst(1'b0, 32'h0);
        tick();
        tick();
        lat = 3;
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || if_pc_o === 32'h0) begin
            failures++;
            $display("FAIL rmid_pre: got req=%b pc=%h, want 1/nonzero", imem_req_o, if_pc_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({imem_req_o, if_pc_o, if_inst_o, if_valid_o, if_excp_o} !== 67'h0) begin
            failures++;
            $display("FAIL rmid_clear: got req=%b pc=%h inst=%h v=%b x=%b, want all 0",
                     imem_req_o, if_pc_o, if_inst_o, if_valid_o, if_excp_o);
        end
        lat = 1;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(ent(32'h0, 1'b0));
        exp_q.push_back(ent(32'h4, 1'b0));
        release_rst(1'b0, 32'h0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rmid_restart: got req=%b addr=%h, want 1/00000000",
                     imem_req_o, imem_addr_o);
        end
        wait_obs(2);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL rmid_stream: got nothing, want %h", exp_e);
            end else begin
                obs_e = obs_q.pop_front();
                if (obs_e !== exp_e) begin
                    failures++;
                    $display("FAIL rmid_stream: got %h, want %h", obs_e, exp_e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = '0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_hold_redirect();
        test_discard();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
